// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared opcodes, state/ALU/immediate encodings and FSM decode helpers
package multicycle_controller_pkg;

   localparam int ALUCTRL_W = 3;
   localparam int STATE_W   = 4;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_B   = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b101;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   // branch marks the state whose PC write is conditional on the compare result
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      aluop_t     alu_op;
      logic       reg_write;
      logic       instr_done;
   } ctl_t;

   function automatic ctl_t decode_state(input state_t s);
      ctl_t c;
      c        = '0;
      c.alu_op = ALUOP_ADD;
      case (s)
         S_FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_write = 1'b1; end
         S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
         S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
         S_MEMREAD:  c.adr_src = 1'b1;
         S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; c.instr_done = 1'b1; end
         S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
         S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_FUNCT; end
         S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = ALUOP_FUNCT; end
         S_ALUWB:    begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
         S_BEQ:      begin c.alu_src_a = 2'b10; c.alu_op = ALUOP_SUB; c.branch = 1'b1; c.instr_done = 1'b1; end
         S_JAL:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
         default:    c.alu_op = ALUOP_ADD;
      endcase
      return c;
   endfunction

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
             (op == OP_B)  || (op == OP_JAL);
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] op, input logic legal);
      state_t ns;
      ns = S_FETCH;
      case (s)
         S_FETCH:  ns = S_DECODE;
         S_DECODE: begin
            if (legal) begin
               case (op)
                  OP_LW, OP_SW: ns = S_MEMADR;
                  OP_R:         ns = S_EXECR;
                  OP_I:         ns = S_EXECI;
                  OP_B:         ns = S_BEQ;
                  OP_JAL:       ns = S_JAL;
                  default:      ns = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  ns = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: ns = S_MEMWB;
         S_EXECR:   ns = S_ALUWB;
         S_EXECI:   ns = S_ALUWB;
         S_JAL:     ns = S_ALUWB;
         default:   ns = S_FETCH;
      endcase
      return ns;
   endfunction

   function automatic logic [1:0] imm_src(input logic [6:0] op);
      case (op)
         OP_SW:   return IMM_S;
         OP_B:    return IMM_B;
         OP_JAL:  return IMM_J;
         default: return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields in, datapath controls out
interface multicycle_controller_if;
   import multicycle_controller_pkg::*;

   logic [6:0]           op;
   logic [2:0]           funct3;
   logic                 funct7b5;
   logic                 Zero;
   logic                 PCWrite;
   logic                 AdrSrc;
   logic                 MemWrite;
   logic                 IRWrite;
   logic [1:0]           ResultSrc;
   logic [1:0]           ALUSrcA;
   logic [1:0]           ALUSrcB;
   logic [1:0]           ImmSrc;
   logic [ALUCTRL_W-1:0] ALUControl;
   logic                 RegWrite;
   logic                 instr_done;
   logic                 illegal_op;

   modport master (
      input  op, funct3, funct7b5, Zero,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, instr_done, illegal_op
   );

   modport slave (
      output op, funct3, funct7b5, Zero,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ImmSrc, ALUControl, RegWrite, instr_done, illegal_op
   );

endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - ALUOp/funct fields to ALUControl, combinational
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  aluop_t               i_alu_op,
   input  logic [2:0]           i_funct3,
   input  logic                 i_op5,
   input  logic                 i_funct7b5,
   output logic [ALUCTRL_W-1:0] o_alu_control
);

   always_comb begin
      o_alu_control = ALU_ADD;
      case (i_alu_op)
         ALUOP_SUB: o_alu_control = ALU_SUB;
         ALUOP_FUNCT: begin
            case (i_funct3)
               // funct7b5 only means subtract for R-type; for I-type it is an immediate bit
               3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  o_alu_control = ALU_SLT;
               3'b110:  o_alu_control = ALU_OR;
               3'b111:  o_alu_control = ALU_AND;
               default: o_alu_control = ALU_ADD;
            endcase
         end
         default: o_alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V control FSM; MC_CTRL_BNE_EN adds bne to the branch state
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   multicycle_controller_if.master bus
);

   state_t r_state;
   ctl_t   r_ctl;
   logic   w_br_ok;
   logic   w_taken;
   logic   w_legal;

`ifdef MC_CTRL_BNE_EN
   assign w_br_ok = (bus.funct3[2:1] == 2'b00);
   assign w_taken = bus.Zero ^ bus.funct3[0];
`else
   assign w_br_ok = 1'b1;
   assign w_taken = bus.Zero;
`endif

   assign w_legal = is_legal_op(bus.op) && ((bus.op != OP_B) || w_br_ok);

   // controls are registered from the next state so they line up with r_state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_FETCH;
         r_ctl   <= decode_state(S_FETCH);
      end else begin
         r_state <= next_state(r_state, bus.op, w_legal);
         r_ctl   <= decode_state(next_state(r_state, bus.op, w_legal));
      end
   end

   assign bus.PCWrite    = rst & (r_ctl.pc_write | (r_ctl.branch & w_taken));
   assign bus.IRWrite    = rst & r_ctl.ir_write;
   assign bus.RegWrite   = rst & r_ctl.reg_write;
   assign bus.MemWrite   = rst & r_ctl.mem_write;
   assign bus.instr_done = rst & r_ctl.instr_done;
   assign bus.illegal_op = rst & (r_state == S_DECODE) & ~w_legal;
   assign bus.AdrSrc     = r_ctl.adr_src;
   assign bus.ResultSrc  = r_ctl.result_src;
   assign bus.ALUSrcA    = r_ctl.alu_src_a;
   assign bus.ALUSrcB    = r_ctl.alu_src_b;
   assign bus.ImmSrc     = imm_src(bus.op);

   alu_decoder u_alu_decoder (
      .i_alu_op      (r_ctl.alu_op),
      .i_funct3      (bus.funct3),
      .i_op5         (bus.op[5]),
      .i_funct7b5    (bus.funct7b5),
      .o_alu_control (bus.ALUControl)
   );

endmodule
